// File: rtl/game_pkg.sv
// game_pkg: state type, sprite counts and coin bit positions shared by the game controller
package game_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, HIT = 2'd2, OVER = 2'd3} state_t;
    localparam int COIN_N = 3;
    localparam int GLACIER_N = 2;
    localparam int COIN_C = 0;
    localparam int COIN_R = 1;
    localparam int COIN_L = 2;
    function automatic logic [1:0] coin_count(input logic [COIN_N-1:0] c);
        return 2'(c[COIN_C]) + 2'(c[COIN_R]) + 2'(c[COIN_L]);
    endfunction
endpackage

// File: rtl/game_score_acc.sv
// game_score_acc: saturating score adder; packed BCD digits when GAME_CTRL_SCORE_BCD_EN is defined
module game_score_acc #(
    parameter int SCORE_W = 8,
    parameter int INC_W = 2
) (
    input  logic [SCORE_W-1:0] score,
    input  logic [INC_W-1:0]   inc,
    output logic [SCORE_W-1:0] next
);
`ifdef GAME_CTRL_SCORE_BCD_EN
    localparam int T_W = INC_W + 4;
    always_comb begin
        logic [SCORE_W-1:0] sum;
        logic [T_W-1:0] c;
        logic [T_W-1:0] t;
        sum = '0;
        c = T_W'(inc);
        for (int i = 0; i < SCORE_W / 4; i++) begin
            t = T_W'(score[4*i +: 4]) + c;
            sum[4*i +: 4] = 4'(t % T_W'(10));
            c = t / T_W'(10);
        end
        next = (c != '0) ? {(SCORE_W / 4){4'h9}} : sum;
    end
`else
    logic [SCORE_W:0] sum;
    assign sum = (SCORE_W + 1)'(score) + (SCORE_W + 1)'(inc);
    assign next = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
`endif
endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: frame-level game sequencer; GAME_CTRL_SCORE_BCD_EN selects a packed BCD score
module game_ctrl
    import game_pkg::*;
#(
    parameter int SCORE_W = 8,
    parameter int LIVES = 3,
    parameter int HIT_FRAMES = 60,
    parameter int COIN_PTS = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_v_sync,
    input  logic                 i_start,
    input  logic                 i_penguin_hit,
    input  logic [GLACIER_N-1:0] i_glacier_hit,
    input  logic [COIN_N-1:0]    i_coin_hit,
    output logic [1:0]           o_state,
    output logic [SCORE_W-1:0]   o_score,
    output logic [2:0]           o_lives,
    output logic [COIN_N-1:0]    o_coin_clear,
    output logic                 o_freeze,
    output logic                 o_flash,
    output logic                 o_game_over
);
    localparam int INC_W = $clog2(3 * COIN_PTS + 1);
    localparam logic [7:0] HIT_INIT = 8'(HIT_FRAMES);
    state_t state;
    logic v_q, s_q, frame_tick, start_tick, crash_acc;
    logic [COIN_N-1:0] coin_acc;
    logic [7:0] cnt, cnt_dec;
    logic [INC_W-1:0] inc;
    logic [SCORE_W-1:0] score_nxt;

    assign frame_tick = i_v_sync & ~v_q;
    assign start_tick = i_start & ~s_q;
    assign cnt_dec = cnt - 8'd1;
    assign inc = INC_W'(COIN_PTS * int'(coin_count(coin_acc)));
    assign o_state = state;

    game_score_acc #(.SCORE_W(SCORE_W), .INC_W(INC_W)) u_score (
        .score(o_score),
        .inc  (inc),
        .next (score_nxt)
    );

    // pixels seen in the tick cycle already belong to the next frame
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            v_q <= 1'b1;
            s_q <= 1'b1;
            coin_acc <= '0;
            crash_acc <= 1'b0;
        end else begin
            v_q <= i_v_sync;
            s_q <= i_start;
            coin_acc <= (frame_tick ? '0 : coin_acc) | ({COIN_N{i_penguin_hit}} & i_coin_hit);
            crash_acc <= (crash_acc & ~frame_tick) | (i_penguin_hit & |i_glacier_hit);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
            o_score <= '0;
            o_lives <= 3'(LIVES);
            o_coin_clear <= '0;
            o_freeze <= 1'b1;
            o_flash <= 1'b0;
            o_game_over <= 1'b0;
            cnt <= '0;
        end else begin
            o_coin_clear <= '0;
            case (state)
                IDLE, OVER: if (start_tick) begin
                    state <= PLAY;
                    o_score <= '0;
                    o_lives <= 3'(LIVES);
                    o_freeze <= 1'b0;
                    o_game_over <= 1'b0;
                end
                PLAY: if (frame_tick) begin
                    o_score <= score_nxt;
                    o_coin_clear <= coin_acc;
                    if (crash_acc && o_lives == 3'd1) begin
                        state <= OVER;
                        o_lives <= '0;
                        o_freeze <= 1'b1;
                        o_game_over <= 1'b1;
                    end else if (crash_acc) begin
                        state <= HIT;
                        o_lives <= o_lives - 3'd1;
                        cnt <= HIT_INIT;
                        o_flash <= HIT_INIT[2];
                    end
                end
                default: if (frame_tick) begin
                    o_score <= score_nxt;
                    o_coin_clear <= coin_acc;
                    cnt <= cnt_dec;
                    o_flash <= cnt_dec[2];
                    if (cnt == 8'd1) state <= PLAY;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: scoreboard bench for game_ctrl, every cycle's outputs checked against a frame model
module tb_game_ctrl;
`ifdef GAME_CTRL_SCORE_BCD_EN
    localparam int SMAX = 99;
`else
    localparam int SMAX = 255;
`endif
    typedef struct {int st; int sc; int lv; int cl; int fl; int fr; int go;} exp_t;
    logic clk = 1'b0;
    logic i_reset, i_v_sync, i_start, i_penguin_hit;
    logic [1:0] i_glacier_hit;
    logic [2:0] i_coin_hit;
    logic [1:0] o_state;
    logic [7:0] o_score;
    logic [2:0] o_lives, o_coin_clear;
    logic o_freeze, o_flash, o_game_over;
    int checks = 0;
    int errors = 0;
    int m_state, m_score, m_lives, m_cnt, m_clr;
    logic [2:0] m_acc;
    logic m_crash, m_vq, m_sq;
    exp_t q[$];

    always #5 clk = ~clk;

    game_ctrl dut (
        .i_clk(clk), .i_reset(i_reset), .i_v_sync(i_v_sync), .i_start(i_start),
        .i_penguin_hit(i_penguin_hit), .i_glacier_hit(i_glacier_hit), .i_coin_hit(i_coin_hit),
        .o_state(o_state), .o_score(o_score), .o_lives(o_lives), .o_coin_clear(o_coin_clear),
        .o_freeze(o_freeze), .o_flash(o_flash), .o_game_over(o_game_over)
    );

    function automatic int enc(input int v);
`ifdef GAME_CTRL_SCORE_BCD_EN
        return ((v / 10) << 4) | (v % 10);
`else
        return v;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic rst, input logic vs, input logic st, input logic pen,
                       input logic [2:0] coin, input logic [1:0] gl);
        exp_t e;
        logic ft, sk;
        i_reset = rst; i_v_sync = vs; i_start = st;
        i_penguin_hit = pen; i_coin_hit = coin; i_glacier_hit = gl;
        ft = vs & ~m_vq;
        sk = st & ~m_sq;
        m_clr = 0;
        if (rst) begin
            m_state = 0; m_score = 0; m_lives = 3; m_cnt = 0;
            m_acc = 0; m_crash = 0; m_vq = 1; m_sq = 1;
        end else begin
            if ((m_state == 0 || m_state == 3) && sk) begin
                m_state = 1; m_score = 0; m_lives = 3;
            end else if ((m_state == 1 || m_state == 2) && ft) begin
                m_score = m_score + $countones(m_acc);
                if (m_score > SMAX) m_score = SMAX;
                m_clr = int'(m_acc);
                if (m_state == 1 && m_crash) begin
                    if (m_lives == 1) begin m_lives = 0; m_state = 3; end
                    else begin m_lives--; m_cnt = 60; m_state = 2; end
                end else if (m_state == 2) begin
                    if (m_cnt == 1) m_state = 1;
                    m_cnt--;
                end
            end
            m_acc = (ft ? 3'b000 : m_acc) | (pen ? coin : 3'b000);
            m_crash = (ft ? 1'b0 : m_crash) | (pen & |gl);
            m_vq = vs;
            m_sq = st;
        end
        e.st = m_state; e.sc = enc(m_score); e.lv = m_lives; e.cl = m_clr;
        e.fl = (m_state == 2) ? ((m_cnt >> 2) & 1) : 0;
        e.fr = (m_state == 0 || m_state == 3) ? 1 : 0;
        e.go = (m_state == 3) ? 1 : 0;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("state", 32'(o_state), e.st);
        check("score", 32'(o_score), e.sc);
        check("lives", 32'(o_lives), e.lv);
        check("coin_clear", 32'(o_coin_clear), e.cl);
        check("flash", 32'(o_flash), e.fl);
        check("freeze", 32'(o_freeze), e.fr);
        check("game_over", 32'(o_game_over), e.go);
    endtask

    task automatic pix(input logic [2:0] coin, input logic [1:0] gl);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, coin, gl);
    endtask

    task automatic tick(input logic st, input logic [2:0] coin);
        cyc(1'b0, 1'b1, st, coin != 3'b000, coin, 2'b00);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00);
    endtask

    task automatic start();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 2'b00);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00);
    endtask

    task automatic hit_frames();
        for (int f = 0; f < 60; f++) begin
            pix(f == 5 ? 3'b010 : 3'b000, f == 10 ? 2'b10 : 2'b00);
            tick(1'b0, 3'b000);
        end
    endtask

    initial begin
        m_vq = 1; m_sq = 1;
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 2'b00);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 2'b00);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 2'b00);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00);
        pix(3'b111, 2'b00);
        tick(1'b0, 3'b000);
        start();
        pix(3'b101, 2'b00);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 2'b11);
        pix(3'b101, 2'b00);
        tick(1'b0, 3'b000);
        pix(3'b000, 2'b01);
        tick(1'b0, 3'b000);
        hit_frames();
        pix(3'b000, 2'b10);
        tick(1'b0, 3'b000);
        hit_frames();
        pix(3'b001, 2'b01);
        tick(1'b0, 3'b000);
        pix(3'b111, 2'b00);
        tick(1'b0, 3'b000);
        pix(3'b011, 2'b00);
        tick(1'b1, 3'b100);
        tick(1'b0, 3'b000);
        for (int f = 0; f < 90; f++) begin
            pix(3'b111, 2'b00);
            tick(1'b0, 3'b000);
        end
        pix(3'b000, 2'b01);
        tick(1'b0, 3'b000);
        pix(3'b111, 2'b11);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'b111, 2'b01);
        pix(3'b010, 2'b01);
        tick(1'b0, 3'b000);
        start();
        tick(1'b0, 3'b000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
